t05_huff_decode: RTL and testbench

//  Huffman bit-stream decoder; the receive-side inverse of the encoder's translation stage.

---
 rtl/t05_huff_decode_if.sv | 30 +++
 rtl/t05_huff_decode.sv | 166 ++++++++++++++++
 tb/tb_t05_huff_decode.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/t05_huff_decode_if.sv
// Bundle of the Huffman decoder's control, bit-stream, node-memory and character-sink signals.
// slave is the decoder side; master is the environment that drives it.
interface t05_huff_decode_if #(
    parameter int ADDR_W = 9
) ();
    logic                  start;
    logic [31:0]           tot_char;
    logic                  bit_in;
    logic                  bit_valid;
    logic                  bit_ready;
    logic                  node_req;
    logic [ADDR_W-1:0]     node_addr;
    logic                  node_ack;
    logic [2*ADDR_W+8:0]   node_data;
    logic [7:0]            char_out;
    logic                  char_valid;
    logic                  char_ready;
    logic                  done;
    logic                  err;

    modport master (
        output start, tot_char, bit_in, bit_valid, node_ack, node_data, char_ready,
        input  bit_ready, node_req, node_addr, char_out, char_valid, done, err
    );

    modport slave (
        input  start, tot_char, bit_in, bit_valid, node_ack, node_data, char_ready,
        output bit_ready, node_req, node_addr, char_out, char_valid, done, err
    );
endinterface

// File: rtl/t05_huff_decode.sv
// Huffman bit-stream decoder: walks a code tree in external node memory one bit per branch
// and emits one character per leaf until the requested number of characters is produced.
module t05_huff_decode #(
    parameter int ADDR_W    = 9,
    parameter int MAX_DEPTH = 127,
    parameter int ROOT      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    t05_huff_decode_if.slave    bus
);
    localparam int                 DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] MAX_D   = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE_D   = DEPTH_W'(1);
    localparam logic [ADDR_W-1:0]  ROOT_A  = ADDR_W'(ROOT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_BIT   = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur;
    logic [DEPTH_W-1:0]  r_depth;
    logic [31:0]         r_count;
    logic [31:0]         r_tot;
    logic                r_leaf;
    logic [7:0]          r_char;
    logic [ADDR_W-1:0]   r_left;
    logic [ADDR_W-1:0]   r_right;
    logic                r_single;
    logic                r_bit_ready;
    logic                r_node_req;
    logic [ADDR_W-1:0]   r_node_addr;
    logic [7:0]          r_char_out;
    logic                r_char_valid;
    logic                r_done;
    logic                r_err;

    logic [31:0]         w_count_inc;
    logic [ADDR_W-1:0]   w_next_node;

    assign w_count_inc = r_count + 32'd1;
    assign w_next_node = bus.bit_in ? r_right : r_left;

    assign bus.bit_ready  = r_bit_ready;
    assign bus.node_req   = r_node_req;
    assign bus.node_addr  = r_node_addr;
    assign bus.char_out   = r_char_out;
    assign bus.char_valid = r_char_valid;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

    // Decoder FSM; every handshake output is registered and changes only on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cur        <= ROOT_A;
            r_depth      <= '0;
            r_count      <= 32'd0;
            r_tot        <= 32'd0;
            r_leaf       <= 1'b0;
            r_char       <= 8'd0;
            r_left       <= '0;
            r_right      <= '0;
            r_single     <= 1'b0;
            r_bit_ready  <= 1'b0;
            r_node_req   <= 1'b0;
            r_node_addr  <= '0;
            r_char_out   <= 8'd0;
            r_char_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_err <= 1'b0;
                        if (bus.tot_char == 32'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_done      <= 1'b0;
                            r_tot       <= bus.tot_char;
                            r_count     <= 32'd0;
                            r_cur       <= ROOT_A;
                            r_depth     <= '0;
                            r_node_req  <= 1'b1;
                            r_node_addr <= ROOT_A;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.node_ack) begin
                        r_leaf     <= bus.node_data[2*ADDR_W+8];
                        r_char     <= bus.node_data[2*ADDR_W+7 -: 8];
                        r_left     <= bus.node_data[2*ADDR_W-1 -: ADDR_W];
                        r_right    <= bus.node_data[ADDR_W-1:0];
                        r_node_req <= 1'b0;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_single <= 1'b0;
                    if (r_leaf && (r_depth != '0)) begin
                        r_char_out   <= r_char;
                        r_char_valid <= 1'b1;
                        r_state      <= S_EMIT;
                    end else if (r_leaf) begin
                        // Root is itself a leaf: burn one bit per symbol so the stream stays aligned.
                        r_single    <= 1'b1;
                        r_bit_ready <= 1'b1;
                        r_state     <= S_BIT;
                    end else if (r_depth == MAX_D) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_bit_ready <= 1'b1;
                        r_state     <= S_BIT;
                    end
                end
                S_BIT: begin
                    if (bus.bit_valid && r_bit_ready) begin
                        r_bit_ready <= 1'b0;
                        r_depth     <= r_depth + ONE_D;
                        if (r_single) begin
                            r_char_out   <= r_char;
                            r_char_valid <= 1'b1;
                            r_state      <= S_EMIT;
                        end else begin
                            r_cur       <= w_next_node;
                            r_node_addr <= w_next_node;
                            r_node_req  <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.char_ready) begin
                        r_char_valid <= 1'b0;
                        r_count      <= w_count_inc;
                        if (w_count_inc == r_tot) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cur       <= ROOT_A;
                            r_depth     <= '0;
                            r_node_req  <= 1'b1;
                            r_node_addr <= ROOT_A;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_t05_huff_decode.sv
// Directed bench for t05_huff_decode: a per-cycle driver models node memory (ack one cycle
// after request), the bit source and the character sink; results are compared to hand values.
module tb_t05_huff_decode;
    localparam int AW = 9;
    localparam int DW = 2*AW + 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    t05_huff_decode_if #(.ADDR_W(AW)) bus ();

    t05_huff_decode #(.ADDR_W(AW), .MAX_DEPTH(2), .ROOT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:7];
    int            n_chk = 0;
    int            n_bad = 0;
    bit            go;
    logic [31:0]   go_tot;
    bit            bq[$];
    logic [7:0]    got[$];
    int            bits_used, req_cycles, rdy_cycles;
    logic          prev_req, prev_ack;
    logic [7:0]    stall_char;
    int            stall_len;
    bit            stall_on;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic lf, input logic [7:0] ch,
                                         input logic [AW-1:0] l, input logic [AW-1:0] r);
        return {lf, ch, l, r};
    endfunction

    task automatic load_tree();
        mem[0] = mk(1'b0, 8'd0,  9'd1, 9'd2);
        mem[1] = mk(1'b1, 8'd65, 9'd0, 9'd0);
        mem[2] = mk(1'b0, 8'd0,  9'd3, 9'd4);
        mem[3] = mk(1'b1, 8'd66, 9'd0, 9'd0);
        mem[4] = mk(1'b1, 8'd70, 9'd0, 9'd0);
        for (int i = 5; i < 8; i++) mem[i] = mk(1'b0, 8'd0, 9'd0, 9'd0);
    endtask

    task automatic reset_stats();
        bits_used = 0; req_cycles = 0; rdy_cycles = 0;
        got.delete(); bq.delete();
    endtask

    // One clock cycle: drive all inputs at the falling edge and log handshakes that will fire.
    task automatic step();
        @(negedge clk);
        bus.node_ack  = bus.node_req && prev_req && !prev_ack;
        bus.node_data = mem[bus.node_addr[2:0]];
        prev_req      = bus.node_req;
        prev_ack      = bus.node_ack;
        bus.start     = go;
        bus.tot_char  = go_tot;
        go            = 1'b0;
        bus.bit_valid = (bq.size() > 0);
        bus.bit_in    = (bq.size() > 0) ? bq[0] : 1'b0;
        bus.char_ready = 1'b1;
        if (stall_len > 0 && (stall_on || (bus.char_valid && bus.char_out == stall_char))) begin
            if (stall_on) begin
                chk("stall_valid", {31'd0, bus.char_valid}, 32'd1);
                chk("stall_char", {24'd0, bus.char_out}, {24'd0, stall_char});
            end
            chk("stall_bit_ready", {31'd0, bus.bit_ready}, 32'd0);
            stall_on = 1'b1;
            bus.char_ready = 1'b0;
            stall_len--;
        end else begin
            stall_on = 1'b0;
        end
        if (bus.bit_valid && bus.bit_ready) begin
            bits_used++;
            void'(bq.pop_front());
        end
        if (bus.char_valid && bus.char_ready) got.push_back(bus.char_out);
        if (bus.node_req) req_cycles++;
        if (bus.bit_ready) rdy_cycles++;
    endtask

    task automatic kick(input logic [31:0] tot);
        go = 1'b1; go_tot = tot;
        step();
        step();
    endtask

    task automatic run(input int budget, input string tag);
        int n = 0;
        while (!(bus.done || bus.err) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.tot_char = 32'd0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
        bus.node_ack = 1'b0; bus.node_data = '0; bus.char_ready = 1'b0;
        go = 1'b0; go_tot = 32'd0; stall_len = 0; stall_on = 1'b0; stall_char = 8'd0;
        prev_req = 1'b0; prev_ack = 1'b0;
        load_tree();
        reset_stats();
        repeat (3) step();
        chk("rst_bit_ready", {31'd0, bus.bit_ready}, 32'd0);
        chk("rst_node_req", {31'd0, bus.node_req}, 32'd0);
        chk("rst_node_addr", {23'd0, bus.node_addr}, 32'd0);
        chk("rst_char_valid", {31'd0, bus.char_valid}, 32'd0);
        chk("rst_char_out", {24'd0, bus.char_out}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        rst_n = 1'b1;
        step();

        // totChar = 0 goes straight to DONE without touching memory or the stream.
        reset_stats();
        go = 1'b1; go_tot = 32'd0;
        step();
        chk("t3_done_before", {31'd0, bus.done}, 32'd0);
        step();
        chk("t3_done", {31'd0, bus.done}, 32'd1);
        repeat (3) step();
        chk("t3_no_req", req_cycles, 32'd0);
        chk("t3_no_bit_ready", rdy_cycles, 32'd0);

        // Three characters from bits 0 / 10 / 11; the trailing bit must be left unused.
        reset_stats();
        bq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        kick(32'd3);
        run(300, "t1");
        chk("t1_nchar", got.size(), 32'd3);
        chk("t1_c0", {24'd0, got[0]}, 32'd65);
        chk("t1_c1", {24'd0, got[1]}, 32'd66);
        chk("t1_c2", {24'd0, got[2]}, 32'd70);
        chk("t1_done", {31'd0, bus.done}, 32'd1);
        chk("t1_err", {31'd0, bus.err}, 32'd0);
        chk("t1_bits", bits_used, 32'd5);

        // Same stream with the sink stalling ten cycles on 'B'.
        reset_stats();
        bq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        stall_char = 8'd66; stall_len = 10;
        kick(32'd3);
        run(300, "t2");
        chk("t2_stall_seen", stall_len, 32'd0);
        chk("t2_nchar", got.size(), 32'd3);
        chk("t2_c0", {24'd0, got[0]}, 32'd65);
        chk("t2_c1", {24'd0, got[1]}, 32'd66);
        chk("t2_c2", {24'd0, got[2]}, 32'd70);
        chk("t2_done", {31'd0, bus.done}, 32'd1);
        chk("t2_bits", bits_used, 32'd5);

        // Single-leaf tree: each symbol still consumes exactly one bit.
        reset_stats();
        mem[0] = mk(1'b1, 8'd75, 9'd0, 9'd0);
        bq = '{1'b1, 1'b0, 1'b1};
        kick(32'd2);
        run(300, "t4");
        chk("t4_nchar", got.size(), 32'd2);
        chk("t4_c0", {24'd0, got[0]}, 32'd75);
        chk("t4_c1", {24'd0, got[1]}, 32'd75);
        chk("t4_done", {31'd0, bus.done}, 32'd1);
        chk("t4_bits", bits_used, 32'd2);

        // Codeword deeper than MAX_DEPTH=2 raises err after the second bit.
        reset_stats();
        load_tree();
        mem[4] = mk(1'b0, 8'd0, 9'd2, 9'd2);
        bq = '{1'b1, 1'b1, 1'b1};
        kick(32'd5);
        run(300, "t5");
        chk("t5_err", {31'd0, bus.err}, 32'd1);
        chk("t5_done", {31'd0, bus.done}, 32'd0);
        chk("t5_nchar", got.size(), 32'd0);
        chk("t5_bits", bits_used, 32'd2);

        // Reset while 'B' is being presented, then a fresh one-character run.
        reset_stats();
        load_tree();
        bq = '{1'b0, 1'b1, 1'b0};
        stall_char = 8'd66; stall_len = 1000;
        kick(32'd3);
        for (int n = 0; n < 300 && !stall_on; n++) step();
        chk("t6_reached_emit", {31'd0, stall_on}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_char_valid", {31'd0, bus.char_valid}, 32'd0);
        chk("t6_rst_bit_ready", {31'd0, bus.bit_ready}, 32'd0);
        chk("t6_rst_node_req", {31'd0, bus.node_req}, 32'd0);
        chk("t6_rst_done", {31'd0, bus.done}, 32'd0);
        chk("t6_nchar_before", got.size(), 32'd1);
        stall_len = 0; stall_on = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        prev_req = 1'b0; prev_ack = 1'b0;
        reset_stats();
        bq = '{1'b0};
        kick(32'd1);
        run(300, "t6");
        chk("t6_nchar", got.size(), 32'd1);
        chk("t6_c0", {24'd0, got[0]}, 32'd65);
        chk("t6_done", {31'd0, bus.done}, 32'd1);
        chk("t6_bits", bits_used, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
